sysid_boot_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the system ID slave on the control bus and consumes its two read-only words. After reset (or on request) it reads word 0 (system ID) and word 1 (build timestamp), latches both, and compares them against build-time expected values. It publishes pass/fail and timeout flags, so boot logic and status LEDs can refuse to proceed on a mismatched or stale FPGA image.

---
 rtl/sysid_boot_checker.sv | 202 ++++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: Avalon-MM read master that fetches the system ID (word 0) and build
// timestamp (word 1), compares both against build-time values and reports pass/fail/timeout.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1720051806,
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] CNT_MAX       = 16'hFFFF;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        to_q, to_d;
    logic [31:0] id_val_q, id_val_d;
    logic [31:0] ts_val_q, ts_val_d;
    logic        expired_s;
    logic        in_txn_s;
    logic        req_entry_s;

    // Sequencer next-state and result flags; capture is tested before expiry so it wins a tie.
    always_comb begin
        state_d   = state_q;
        auto_d    = auto_q;
        done_d    = done_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        to_d      = to_q;
        id_val_d  = id_val_q;
        ts_val_d  = ts_val_q;
        expired_s = (cnt_q >= TIMEOUT_LIMIT);
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = ID_REQ;
                    auto_d  = 1'b0;
                    done_d  = 1'b0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    to_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ID_REQ: begin
                if (expired_s) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    done_d  = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_d = ID_WAIT;
                end else begin
                    state_d = ID_REQ;
                end
            end
            ID_WAIT: begin
                if (avm_readdatavalid) begin
                    id_val_d = avm_readdata;
                    state_d  = TS_REQ;
                end else if (expired_s) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ID_WAIT;
                end
            end
            TS_REQ: begin
                if (expired_s) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    done_d  = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_d = TS_WAIT;
                end else begin
                    state_d = TS_REQ;
                end
            end
            TS_WAIT: begin
                if (avm_readdatavalid) begin
                    ts_val_d = avm_readdata;
                    state_d  = FINISH;
                end else if (expired_s) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = TS_WAIT;
                end
            end
            FINISH: begin
                id_ok_d = (id_val_q == EXPECTED_ID);
                ts_ok_d = (ts_val_q == EXPECTED_TS);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-request cycle budget and bus/busy outputs derived from the upcoming state.
    always_comb begin
        in_txn_s    = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                      (state_q == TS_REQ) || (state_q == TS_WAIT);
        req_entry_s = (state_d != state_q) && ((state_d == ID_REQ) || (state_d == TS_REQ));
        if (req_entry_s) begin
            cnt_d = 16'd0;
        end else if (in_txn_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        read_d = (state_d == ID_REQ) || (state_d == TS_REQ);
        addr_d = (state_d == TS_REQ) || (state_d == TS_WAIT);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            auto_q   <= AUTO_START;
            read_q   <= 1'b0;
            addr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            to_q     <= 1'b0;
            id_val_q <= 32'd0;
            ts_val_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            auto_q   <= auto_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            to_q     <= to_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = to_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: directed table, hand sequences and randomized slave timing
// checked against an outcome model computed from per-read latencies.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1720051806;
    localparam int          T      = 8;

    typedef struct packed {
        int          w0;
        int          d0;
        int          w1;
        int          d1;
        bit          resp0;
        bit          resp1;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          e_done;
        bit          e_id_ok;
        bit          e_ts_ok;
        bit          e_to;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start_m;
    logic        waitreq;
    logic        rdv;
    logic [31:0] rdata;

    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic        avm_address_m, avm_read_m, busy_m, done_m, id_ok_m, ts_ok_m, timeout_m;
    logic [31:0] id_value_m, ts_value_m;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_id = 32'd0;
    logic [31:0] m_ts = 32'd0;

    vec_t        s_cfg;
    int          s_wcnt;
    int          s_pend;
    logic        s_paddr;
    logic        acc_q[$];
    vec_t        tbl[10];

    always #5 clock = ~clock;

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(waitreq),
        .avm_readdatavalid(rdv), .avm_readdata(rdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
        .id_value(id_value), .ts_value(ts_value)
    );

    sysid_boot_checker #(
        .AUTO_START(1'b0)
    ) dut_m (
        .clock(clock), .reset_n(reset_n), .start(start_m),
        .avm_address(avm_address_m), .avm_read(avm_read_m), .avm_waitrequest(waitreq),
        .avm_readdatavalid(rdv), .avm_readdata(rdata),
        .busy(busy_m), .done(done_m), .id_ok(id_ok_m), .ts_ok(ts_ok_m), .timeout(timeout_m),
        .id_value(id_value_m), .ts_value(ts_value_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Outcome of one check from read latencies: capture offset c = w+1+d must be <= T+1.
    function automatic void predict(input vec_t v, output int done_k, output bit to,
                                    output bit cap0, output bit cap1, output int c0);
        int c1;
        c0   = v.w0 + 1 + v.d0;
        c1   = v.w1 + 1 + v.d1;
        cap0 = v.resp0 && (c0 <= T + 1);
        cap1 = cap0 && v.resp1 && (c1 <= T + 1);
        if (!cap0) begin
            done_k = T + 1;
            to     = 1'b1;
        end else if (!cap1) begin
            done_k = c0 + T + 1;
            to     = 1'b1;
        end else begin
            done_k = c0 + c1 + 1;
            to     = 1'b0;
        end
    endfunction

    // Slave responder, called at each falling edge to set inputs for the next rising edge.
    task automatic slave_drive();
        rdv   = 1'b0;
        rdata = $urandom();
        if (s_pend > 0) begin
            if (s_pend == 1) begin
                rdv   = 1'b1;
                rdata = s_paddr ? s_cfg.ts_data : s_cfg.id_data;
            end
            s_pend--;
        end
        waitreq = 1'b0;
        if (avm_read) begin
            if (s_wcnt < (avm_address ? s_cfg.w1 : s_cfg.w0)) begin
                waitreq = 1'b1;
                s_wcnt++;
            end else begin
                s_wcnt = 0;
                acc_q.push_back(avm_address);
                if (avm_address ? s_cfg.resp1 : s_cfg.resp0) begin
                    s_pend  = avm_address ? s_cfg.d1 : s_cfg.d0;
                    s_paddr = avm_address;
                end
            end
        end else begin
            s_wcnt = 0;
        end
    endtask

    task automatic run_check(input vec_t v, input bit auto_go, input bit poke_busy, input bit poke_fin);
        int done_k, c0, lim0, lim1;
        bit to, cap0, cap1, er, ea;
        predict(v, done_k, to, cap0, cap1, c0);
        if (cap0) m_id = v.id_data;
        if (cap1) m_ts = v.ts_data;
        lim0 = (v.w0 < T) ? v.w0 : T;
        lim1 = (v.w1 < T) ? v.w1 : T;
        s_cfg = v;
        s_pend = 0;
        s_wcnt = 0;
        acc_q.delete();
        waitreq = 1'b0;
        rdv = 1'b0;
        if (auto_go) reset_n = 1'b1;
        else start = 1'b1;
        for (int k = 0; k <= v.e_done + 2; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k < v.e_done) begin
                er = (k <= lim0) || (cap0 && (k >= c0) && ((k - c0) <= lim1));
                ea = cap0 && (k >= c0);
                chk("busy_during", 32'(busy), 32'd1);
                chk("done_during", 32'(done), 32'd0);
                chk("flags_during", 32'({id_ok, ts_ok, timeout}), 32'd0);
                chk("avm_read", 32'(avm_read), 32'(er));
                if (er) chk("avm_address", 32'(avm_address), 32'(ea));
            end else begin
                chk("done_end", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("read_end", 32'(avm_read), 32'd0);
                chk("id_ok", 32'(id_ok), 32'(v.e_id_ok));
                chk("ts_ok", 32'(ts_ok), 32'(v.e_ts_ok));
                chk("timeout", 32'(timeout), 32'(v.e_to));
                chk("id_value", id_value, m_id);
                chk("ts_value", ts_value, m_ts);
            end
            slave_drive();
            if (poke_busy && (k == 1)) start = 1'b1;
            if (poke_fin && (k == v.e_done - 1)) start = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: summary not reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   dk, c0;
        bit   to, cp0, cp1;
        logic [1:0] addrs;

        tbl[0] = '{0, 1, 0, 1, 1'b1, 1'b1, EXP_ID, EXP_TS, 5, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{0, 1, 0, 1, 1'b1, 1'b1, EXP_ID, 32'd1720051805, 5, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3, 2, 3, 2, 1'b1, 1'b1, EXP_ID, EXP_TS, 13, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{0, 1, 0, 1, 1'b1, 1'b0, EXP_ID, EXP_TS, 11, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{0, 8, 0, 1, 1'b1, 1'b1, EXP_ID, EXP_TS, 12, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{0, 9, 0, 1, 1'b1, 1'b1, EXP_ID, EXP_TS, 9, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{9, 1, 0, 1, 1'b1, 1'b1, EXP_ID, EXP_TS, 9, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{0, 1, 2, 6, 1'b1, 1'b1, 32'h5, EXP_TS, 12, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{8, 1, 0, 1, 1'b1, 1'b1, EXP_ID, EXP_TS, 9, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1, 1, 1, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, EXP_TS ^ 32'h8000_0000, 7, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        start_m = 1'b0;
        waitreq = 1'b0;
        rdv     = 1'b0;
        rdata   = 32'd0;
        s_cfg   = tbl[0];
        s_wcnt  = 0;
        s_pend  = 0;
        s_paddr = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ctrl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
        chk("rst_manual_inst", 32'(|{avm_read_m, avm_address_m, busy_m, done_m, id_ok_m, ts_ok_m,
                                     timeout_m, id_value_m, ts_value_m}), 32'd0);

        // Auto-start check after reset release, zero-wait slave.
        run_check(tbl[0], 1'b1, 1'b0, 1'b0);
        addrs = 2'b11;
        if (acc_q.size() >= 2) addrs = {acc_q[0], acc_q[1]};
        chk("accepted_reads", 32'(acc_q.size()), 32'd2);
        chk("accepted_addrs", 32'(addrs), 32'd1);
        chk("manual_stays_idle", 32'({busy_m, avm_read_m}), 32'd0);

        for (int i = 1; i < 10; i++) begin
            run_check(tbl[i], 1'b0, 1'((i & 1) != 0), 1'((i & 2) != 0));
            if (tbl[i].resp0 && !tbl[i].resp1) begin
                rdv   = 1'b1;
                rdata = 32'hDEAD_BEEF;
                @(negedge clock);
                rdv = 1'b0;
                @(negedge clock);
                chk("late_rdv_ts", ts_value, m_ts);
                chk("late_rdv_id", id_value, m_id);
                chk("late_rdv_flags", 32'({done, timeout, busy}), 32'd6);
            end
        end

        // Manual-start instance only launches on a start pulse.
        start_m = 1'b1;
        @(negedge clock);
        start_m = 1'b0;
        chk("manual_start", 32'({busy_m, avm_read_m, avm_address_m, done_m}), 32'd12);

        // Reset asserted while waiting for the timestamp data.
        v = tbl[0];
        v.d1 = 3;
        s_cfg = v;
        s_pend = 0;
        s_wcnt = 0;
        waitreq = 1'b0;
        rdv = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            start = 1'b0;
            slave_drive();
        end
        @(negedge clock);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
        chk("mid_rst_ts", ts_value, 32'd0);
        chk("mid_rst_id", id_value, 32'd0);
        chk("mid_rst_manual", 32'(busy_m), 32'd0);
        m_id = 32'd0;
        m_ts = 32'd0;
        rdv = 1'b0;
        repeat (2) @(negedge clock);
        run_check(tbl[0], 1'b1, 1'b0, 1'b0);

        // Randomized slave timing and data against the outcome model.
        for (int i = 0; i < 40; i++) begin
            v.w0 = int'($urandom_range(0, 4));
            v.d0 = int'($urandom_range(1, 5));
            v.w1 = int'($urandom_range(0, 4));
            v.d1 = int'($urandom_range(1, 5));
            v.resp0 = ($urandom_range(0, 7) != 0);
            v.resp1 = ($urandom_range(0, 7) != 0);
            v.id_data = ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom());
            v.ts_data = ($urandom_range(0, 1) != 0) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
            predict(v, dk, to, cp0, cp1, c0);
            v.e_done  = dk;
            v.e_to    = to;
            v.e_id_ok = !to && (v.id_data == EXP_ID);
            v.e_ts_ok = !to && (v.ts_data == EXP_TS);
            run_check(v, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
